trax_turn_sequencer: RTL and testbench

TRAX_TURN_SEQUENCER -- requirements
Module: trax_turn_sequencer

---
 rtl/trax_turn_sequencer.sv | 175 +++++++++++++++++
 tb/tb_trax_turn_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trax_turn_sequencer.sv
// Turn sequencer for the Trax move pipeline: walks one opponent move and one
// own move through update, auto-complete, copy, shift and choose phases.
module trax_turn_sequencer #(
  parameter int TIMEOUT     = 4095,
  parameter int AC_MAX_ITER = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        end_receive,
  input  logic        color,
  input  logic [21:0] move_rx,
  output logic [21:0] move_cur,
  output logic [21:0] move_tx,
  output logic        start_transmit,
  output logic        upd_start,
  input  logic        upd_done,
  output logic        ac_start,
  input  logic        ac_done,
  output logic        copy_start,
  input  logic        copy_done,
  output logic        shd_start,
  input  logic        shd_done,
  output logic        shr_start,
  input  logic        shr_done,
  output logic        choose_start,
  input  logic        choose_done,
  input  logic        ac_changed,
  input  logic        need_shd,
  input  logic        need_shr,
  input  logic [21:0] chosen_move,
  output logic        busy,
  output logic [3:0]  phase,
  output logic [15:0] round,
  output logic        error,
  output logic        overrun
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int ACW = $clog2(AC_MAX_ITER + 1);
  localparam logic [TW-1:0]  TMO_LIM = TW'(TIMEOUT - 1);
  localparam logic [ACW-1:0] AC_LIM  = ACW'(AC_MAX_ITER);
  localparam logic [21:0]    WHITE_OPEN = 22'h100000;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_UPD = 4'd1, S_AC = 4'd2, S_COPY = 4'd3, S_SHD = 4'd4,
    S_SHR = 4'd5, S_CHOOSE = 4'd6, S_TX = 4'd7, S_ERR = 4'd15
  } state_t;

  state_t          state, state_d, post_copy;
  logic            enter, first_cyc, done_in, done_ok, wait_st, rise;
  logic            er_q, color_seen, pass, shr_pend;
  logic [TW-1:0]   tmo_cnt;
  logic [ACW-1:0]  ac_cnt;

  assign rise = end_receive & ~er_q;

  // done is ignored in the start cycle; only the owning phase listens
  always_comb begin
    done_in = 1'b0;
    case (state)
      S_UPD:    done_in = upd_done;
      S_AC:     done_in = ac_done;
      S_COPY:   done_in = copy_done;
      S_SHD:    done_in = shd_done;
      S_SHR:    done_in = shr_done;
      S_CHOOSE: done_in = choose_done;
      default:  done_in = 1'b0;
    endcase
    done_ok   = done_in & ~first_cyc;
    wait_st   = state inside {S_UPD, S_AC, S_COPY, S_SHD, S_SHR, S_CHOOSE};
    post_copy = pass ? S_TX : S_CHOOSE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    enter   = 1'b0;
    case (state)
      S_IDLE: if (rise) begin state_d = S_UPD; enter = 1'b1; end
      S_UPD:  if (done_ok) begin state_d = S_AC; enter = 1'b1; end
      S_AC: if (done_ok) begin
        state_d = (ac_changed && ac_cnt < AC_LIM) ? S_AC : S_COPY;
        enter   = 1'b1;
      end
      S_COPY: if (done_ok) begin
        state_d = need_shd ? S_SHD : (need_shr ? S_SHR : post_copy);
        enter   = 1'b1;
      end
      S_SHD:    if (done_ok) begin state_d = shr_pend ? S_SHR : post_copy; enter = 1'b1; end
      S_SHR:    if (done_ok) begin state_d = post_copy; enter = 1'b1; end
      S_CHOOSE: if (done_ok) begin state_d = S_UPD; enter = 1'b1; end
      S_TX:     state_d = S_IDLE;
      default:  state_d = S_ERR;
    endcase
    if (wait_st && !done_ok && tmo_cnt == TMO_LIM) begin
      state_d = S_ERR;
      enter   = 1'b0;
    end
  end

  always_comb begin
    busy  = (state != S_IDLE);
    phase = state;
    error = (state == S_ERR);
  end

  // start pulses are registered so they land in the first cycle of the new state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_start      <= 1'b0;
      ac_start       <= 1'b0;
      copy_start     <= 1'b0;
      shd_start      <= 1'b0;
      shr_start      <= 1'b0;
      choose_start   <= 1'b0;
      start_transmit <= 1'b0;
      first_cyc      <= 1'b0;
    end else begin
      upd_start      <= enter && state_d == S_UPD;
      ac_start       <= enter && state_d == S_AC;
      copy_start     <= enter && state_d == S_COPY;
      shd_start      <= enter && state_d == S_SHD;
      shr_start      <= enter && state_d == S_SHR;
      choose_start   <= enter && state_d == S_CHOOSE;
      start_transmit <= enter && state_d == S_TX;
      first_cyc      <= enter;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      er_q       <= 1'b0;
      color_seen <= 1'b0;
      pass       <= 1'b0;
      shr_pend   <= 1'b0;
      move_cur   <= '0;
      move_tx    <= '0;
      round      <= '0;
      overrun    <= 1'b0;
      ac_cnt     <= '0;
      tmo_cnt    <= '0;
    end else begin
      er_q <= end_receive;
      if (state == S_IDLE && rise) begin
        color_seen <= 1'b1;
        // white opens the game: skip the opponent half and play the opening tile
        if (!color_seen && !color) begin
          move_cur <= WHITE_OPEN;
          move_tx  <= WHITE_OPEN;
          pass     <= 1'b1;
        end else begin
          move_cur <= move_rx;
          pass     <= 1'b0;
        end
      end
      if (rise && state != S_IDLE && state != S_ERR) overrun <= 1'b1;
      if (state == S_COPY && done_ok) shr_pend <= need_shr;
      if (state == S_CHOOSE && done_ok) begin
        move_cur <= chosen_move;
        move_tx  <= chosen_move;
        pass     <= 1'b1;
      end
      if (state == S_TX && round != 16'hFFFF) round <= round + 16'd1;
      if (enter && state_d == S_AC)
        ac_cnt <= (state == S_AC) ? ac_cnt + ACW'(1) : ACW'(1);
      if (enter || state_d != state) tmo_cnt <= '0;
      else if (wait_st)              tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_trax_turn_sequencer.sv
// Randomized bench for trax_turn_sequencer: a phase-list model predicts the
// order of start pulses per turn, the resulting moves and round count.
module tb_trax_turn_sequencer;
  logic        clk = 1'b0, reset = 1'b0, end_receive = 1'b0, color = 1'b0;
  logic [21:0] move_rx = '0, chosen_move = '0;
  logic        upd_done = 0, ac_done = 0, copy_done = 0, shd_done = 0, shr_done = 0, choose_done = 0;
  logic        ac_changed = 0, need_shd = 0, need_shr = 0;
  logic [21:0] move_cur, move_tx;
  logic        start_transmit, upd_start, ac_start, copy_start, shd_start, shr_start, choose_start;
  logic        busy, error, overrun;
  logic [3:0]  phase;
  logic [15:0] round;

  int cyc = 0, n_cmp = 0, n_bad = 0;
  int got_seq[$], got_cyc[$], exp_seq[$];
  logic [21:0] upd_mv[$];
  bit cfg_shd, cfg_shr, first_edge, turn_done;
  logic [21:0] cfg_chs, exp_mtx;
  int exp_round, turn_T;

  trax_turn_sequencer dut (
    .clk(clk), .reset(reset), .end_receive(end_receive), .color(color), .move_rx(move_rx),
    .move_cur(move_cur), .move_tx(move_tx), .start_transmit(start_transmit),
    .upd_start(upd_start), .upd_done(upd_done), .ac_start(ac_start), .ac_done(ac_done),
    .copy_start(copy_start), .copy_done(copy_done), .shd_start(shd_start), .shd_done(shd_done),
    .shr_start(shr_start), .shr_done(shr_done), .choose_start(choose_start), .choose_done(choose_done),
    .ac_changed(ac_changed), .need_shd(need_shd), .need_shr(need_shr), .chosen_move(chosen_move),
    .busy(busy), .phase(phase), .round(round), .error(error), .overrun(overrun));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] starts();
    return {upd_start, ac_start, copy_start, shd_start, shr_start, choose_start, start_transmit};
  endfunction

  function automatic int start_code();
    if (upd_start) return 1;
    if (ac_start) return 2;
    if (copy_start) return 3;
    if (shd_start) return 4;
    if (shr_start) return 5;
    if (choose_start) return 6;
    if (start_transmit) return 7;
    return 0;
  endfunction

  // side inputs carry junk whenever their done is low
  task automatic clear_dones();
    {upd_done, ac_done, copy_done, shd_done, shr_done, choose_done} = '0;
    ac_changed  = 1'($urandom_range(0, 1));
    need_shd    = 1'($urandom_range(0, 1));
    need_shr    = 1'($urandom_range(0, 1));
    chosen_move = 22'($urandom());
  endtask

  task automatic set_done(input int p, input bit chg);
    case (p)
      1: upd_done = 1'b1;
      2: begin ac_done = 1'b1; ac_changed = chg; end
      3: begin copy_done = 1'b1; need_shd = cfg_shd; need_shr = cfg_shr; end
      4: shd_done = 1'b1;
      5: shr_done = 1'b1;
      6: begin choose_done = 1'b1; chosen_move = cfg_chs; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; end_receive = 1'b0;
    clear_dones();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    first_edge = 1'b1; exp_round = 0; exp_mtx = '0;
  endtask

  // Plays one full turn: the first chg_n AC passes of each half report a change.
  task automatic do_turn(input int chg_n, input bit rnd, input bit ovr, input logic [21:0] mv);
    int pend, cnt, ac_pass, inj_cyc;
    bit injected;
    got_seq.delete(); got_cyc.delete(); upd_mv.delete();
    pend = 0; cnt = 0; ac_pass = 0; injected = 0; inj_cyc = 0; turn_done = 0;
    @(negedge clk);
    move_rx = mv; end_receive = 1'b1; turn_T = cyc;
    for (int g = 0; g < 400 && !turn_done; g++) begin
      int p;
      @(negedge clk);
      clear_dones();
      if (cyc == turn_T + 2) end_receive = 1'b0;
      if (injected && cyc == inj_cyc + 2) end_receive = 1'b0;
      p = start_code();
      if (p != 0) begin
        got_seq.push_back(p); got_cyc.push_back(cyc - turn_T);
        if (p == 1) begin upd_mv.push_back(move_cur); ac_pass = 0; end
        if (p == 7) turn_done = 1;
        else begin
          pend = p; cnt = rnd ? $urandom_range(1, 3) : 1;
          if (rnd && $urandom_range(0, 2) == 0) set_done(p, 1'b1);
        end
        if (p == 2 && ovr && !injected) begin end_receive = 1'b1; injected = 1; inj_cyc = cyc; end
      end else if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin
          set_done(pend, pend == 2 && ac_pass < chg_n);
          if (pend == 2) ac_pass++;
          pend = 0;
        end else if (rnd && $urandom_range(0, 1) == 1) set_done(pend == 6 ? 1 : pend + 1, 1'b1);
      end
    end
    @(negedge clk);
    clear_dones(); end_receive = 1'b0;
    n_cmp++;
    if (!turn_done) begin n_bad++; $display("FAIL turn_no_transmit starts_seen=%0d required start_transmit", got_seq.size()); end
  endtask

  task automatic model_half(input int chg_n);
    int n;
    n = (chg_n + 1 > 8) ? 8 : chg_n + 1;
    exp_seq.push_back(1);
    repeat (n) exp_seq.push_back(2);
    exp_seq.push_back(3);
    if (cfg_shd) exp_seq.push_back(4);
    if (cfg_shr) exp_seq.push_back(5);
  endtask

  task automatic model_turn(input bit wf, input int chg_n);
    exp_seq.delete();
    if (!wf) begin model_half(chg_n); exp_seq.push_back(6); end
    model_half(chg_n);
    exp_seq.push_back(7);
    exp_mtx = wf ? 22'h100000 : cfg_chs;
    if (exp_round < 65535) exp_round++;
    first_edge = 0;
  endtask

  function automatic bit seq_ok();
    if (got_seq.size() != exp_seq.size()) return 0;
    foreach (exp_seq[i]) if (got_seq[i] != exp_seq[i]) return 0;
    return 1;
  endfunction

  function automatic bit mv_ok(input bit wf, input logic [21:0] mv);
    if (upd_mv.size() != (wf ? 1 : 2)) return 0;
    if (upd_mv[0] !== (wf ? 22'h100000 : mv)) return 0;
    if (!wf && upd_mv[1] !== cfg_chs) return 0;
    return 1;
  endfunction

  function automatic int cyc_of(input int p);
    foreach (got_seq[i]) if (got_seq[i] == p) return got_cyc[i];
    return -1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (starts() !== 7'b0) begin n_bad++; $display("FAIL reset_starts got %b required 0", starts()); end
    n_cmp++; if ({busy, error, overrun, phase} !== 7'b0) begin n_bad++; $display("FAIL reset_status got %b required 0", {busy, error, overrun, phase}); end
    n_cmp++; if ({move_cur, move_tx, round} !== '0) begin n_bad++; $display("FAIL reset_regs got %h required 0", {move_cur, move_tx, round}); end
    reset = 1'b1; first_edge = 1; exp_round = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || phase !== 4'd0) begin n_bad++; $display("FAIL reset_release busy=%b phase=%0d required 0/0", busy, phase); end
  endtask

  task automatic test_black_timing();
    logic [21:0] mv;
    do_reset();
    color = 1'b1; cfg_shd = 0; cfg_shr = 0; cfg_chs = 22'h300002;
    do_turn(0, 0, 0, 22'h200405);
    model_turn(1'b0, 0);
    n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL black_seq got %0d starts required %0d", got_seq.size(), exp_seq.size()); end
    n_cmp++; if (cyc_of(1) != 1) begin n_bad++; $display("FAIL black_upd_time got T+%0d required T+1", cyc_of(1)); end
    n_cmp++; if (cyc_of(6) != 7) begin n_bad++; $display("FAIL black_choose_time got T+%0d required T+7", cyc_of(6)); end
    n_cmp++; if (cyc_of(7) != 15) begin n_bad++; $display("FAIL black_tx_time got T+%0d required T+15", cyc_of(7)); end
    n_cmp++; if (move_tx !== 22'h300002) begin n_bad++; $display("FAIL black_move_tx got %h required 300002", move_tx); end
    n_cmp++; if (round !== 16'd1) begin n_bad++; $display("FAIL black_round got %0d required 1", round); end
    n_cmp++; if (!mv_ok(1'b0, 22'h200405)) begin n_bad++; $display("FAIL black_move_cur got %0d upd moves required 2", upd_mv.size()); end
    // colour is sampled only on the first edge of a game
    color = 1'b0; cfg_chs = 22'($urandom()); mv = 22'($urandom());
    do_turn(0, 0, 0, mv);
    model_turn(1'b0, 0);
    n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL black_second_seq got %0d starts required %0d", got_seq.size(), exp_seq.size()); end
    n_cmp++; if (move_tx !== exp_mtx || round !== 16'(exp_round)) begin n_bad++; $display("FAIL black_second_state got %h/%0d required %h/%0d", move_tx, round, exp_mtx, exp_round); end
  endtask

  task automatic test_white();
    logic [21:0] mv;
    do_reset();
    color = 1'b0; cfg_shd = 0; cfg_shr = 0; cfg_chs = 22'($urandom()); mv = 22'($urandom());
    do_turn(0, 0, 0, mv);
    model_turn(1'b1, 0);
    n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL white_seq got %0d starts required %0d", got_seq.size(), exp_seq.size()); end
    n_cmp++; if (cyc_of(6) != -1) begin n_bad++; $display("FAIL white_no_choose got T+%0d required none", cyc_of(6)); end
    n_cmp++; if (cyc_of(7) != 7) begin n_bad++; $display("FAIL white_tx_time got T+%0d required T+7", cyc_of(7)); end
    n_cmp++; if (move_tx !== 22'h100000) begin n_bad++; $display("FAIL white_move_tx got %h required 100000", move_tx); end
    n_cmp++; if (!mv_ok(1'b1, mv)) begin n_bad++; $display("FAIL white_move_cur got %0d upd moves required 1", upd_mv.size()); end
  endtask

  task automatic test_ac_cap();
    int chg[3] = '{6, 7, 50};
    do_reset();
    color = 1'b1; cfg_shd = 0; cfg_shr = 0;
    foreach (chg[k]) begin
      int n_ac, want;
      cfg_chs = 22'($urandom());
      do_turn(chg[k], 0, 0, 22'($urandom()));
      model_turn(1'b0, chg[k]);
      n_ac = 0;
      foreach (got_seq[i]) if (got_seq[i] == 2) n_ac++;
      want = 2 * ((chg[k] + 1 > 8) ? 8 : chg[k] + 1);
      n_cmp++; if (n_ac != want) begin n_bad++; $display("FAIL ac_cap_count chg=%0d got %0d required %0d", chg[k], n_ac, want); end
      n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL ac_cap_seq chg=%0d got %0d starts required %0d", chg[k], got_seq.size(), exp_seq.size()); end
    end
  endtask

  task automatic test_shifts();
    do_reset();
    color = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int c;
      {cfg_shd, cfg_shr} = 2'(k);
      cfg_chs = 22'($urandom()); c = $urandom_range(0, 3);
      do_turn(c, 1, 0, 22'($urandom()));
      model_turn(1'b0, c);
      n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL shifts_seq shd=%0d shr=%0d got %0d starts required %0d", cfg_shd, cfg_shr, got_seq.size(), exp_seq.size()); end
      n_cmp++; if (move_tx !== exp_mtx) begin n_bad++; $display("FAIL shifts_move_tx got %h required %h", move_tx, exp_mtx); end
    end
  endtask

  task automatic test_random();
    do_reset();
    color = 1'($urandom_range(0, 1));
    for (int t = 0; t < 8; t++) begin
      int c; bit wf; logic [21:0] mv;
      cfg_shd = 1'($urandom_range(0, 1)); cfg_shr = 1'($urandom_range(0, 1));
      cfg_chs = 22'($urandom()); mv = 22'($urandom()); c = $urandom_range(0, 9);
      wf = first_edge && !color;
      do_turn(c, 1, 0, mv);
      model_turn(wf, c);
      n_cmp++; if (!seq_ok()) begin n_bad++; $display("FAIL random_seq turn=%0d got %0d starts required %0d", t, got_seq.size(), exp_seq.size()); end
      n_cmp++; if (!mv_ok(wf, mv)) begin n_bad++; $display("FAIL random_move_cur turn=%0d got %0d upd moves", t, upd_mv.size()); end
      n_cmp++; if (move_tx !== exp_mtx || round !== 16'(exp_round)) begin n_bad++; $display("FAIL random_state turn=%0d got %h/%0d required %h/%0d", t, move_tx, round, exp_mtx, exp_round); end
      color = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_overrun();
    do_reset();
    color = 1'b1; cfg_shd = 0; cfg_shr = 1; cfg_chs = 22'($urandom());
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_initial got %b required 0", overrun); end
    do_turn(1, 0, 1, 22'($urandom()));
    model_turn(1'b0, 1);
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set got %b required 1", overrun); end
    n_cmp++; if (!seq_ok() || move_tx !== exp_mtx) begin n_bad++; $display("FAIL overrun_seq got %0d starts required %0d", got_seq.size(), exp_seq.size()); end
    do_turn(0, 1, 0, 22'($urandom()));
    model_turn(1'b0, 0);
    n_cmp++; if (overrun !== 1'b1 || !seq_ok()) begin n_bad++; $display("FAIL overrun_sticky got %b required 1", overrun); end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    color = 1'b1;
    @(negedge clk); move_rx = 22'h012345; end_receive = 1'b1; t0 = cyc;
    @(negedge clk); end_receive = 1'b0;
    while (cyc < t0 + 4090) @(negedge clk);
    n_cmp++; if (error !== 1'b0 || phase !== 4'd1) begin n_bad++; $display("FAIL timeout_early error=%b phase=%0d required 0/1", error, phase); end
    while (cyc < t0 + 4100) @(negedge clk);
    n_cmp++; if (error !== 1'b1 || phase !== 4'd15) begin n_bad++; $display("FAIL timeout_err error=%b phase=%0d required 1/15", error, phase); end
    n_cmp++; if (busy !== 1'b1 || starts() !== 7'b0) begin n_bad++; $display("FAIL timeout_quiet busy=%b starts=%b required 1/0", busy, starts()); end
    end_receive = 1'b1;
    {upd_done, ac_done, copy_done, shd_done, shr_done, choose_done} = '1;
    repeat (3) @(negedge clk);
    clear_dones(); end_receive = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (phase !== 4'd15 || overrun !== 1'b0 || starts() !== 7'b0) begin n_bad++; $display("FAIL timeout_ignore phase=%0d overrun=%b required 15/0", phase, overrun); end
    do_reset();
    n_cmp++; if (error !== 1'b0 || phase !== 4'd0) begin n_bad++; $display("FAIL timeout_reset error=%b phase=%0d required 0/0", error, phase); end
  endtask

  task automatic test_reset_mid_copy();
    int last_p, t0; bit seen, quiet;
    do_reset();
    color = 1'b1; cfg_shd = 0; cfg_shr = 0; cfg_chs = 22'($urandom());
    @(negedge clk); move_rx = {2'b01, 20'($urandom())}; end_receive = 1'b1; t0 = cyc;
    last_p = 0; seen = 0;
    for (int g = 0; g < 30 && !seen; g++) begin
      @(negedge clk);
      clear_dones();
      if (cyc == t0 + 2) end_receive = 1'b0;
      if (copy_start) seen = 1;
      else begin
        if (last_p != 0) set_done(last_p, 1'b0);
        last_p = upd_start ? 1 : (ac_start ? 2 : 0);
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL midcopy_reach got no copy_start required copy_start"); end
    end_receive = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (starts() !== 7'b0 || busy !== 1'b0 || phase !== 4'd0) begin n_bad++; $display("FAIL midcopy_async starts=%b busy=%b phase=%0d required 0", starts(), busy, phase); end
    n_cmp++; if ({move_cur, move_tx, round, error, overrun} !== '0) begin n_bad++; $display("FAIL midcopy_regs got %h required 0", {move_cur, move_tx, round}); end
    quiet = 1;
    repeat (3) begin @(negedge clk); if (copy_start !== 1'b0 || busy !== 1'b0) quiet = 0; end
    n_cmp++; if (!quiet) begin n_bad++; $display("FAIL midcopy_hold got activity during reset required none"); end
    reset = 1'b1; first_edge = 1; exp_round = 0;
    color = 1'b0;
    do_turn(0, 0, 0, 22'($urandom()));
    model_turn(1'b1, 0);
    n_cmp++; if (!seq_ok() || move_tx !== 22'h100000) begin n_bad++; $display("FAIL midcopy_newgame move_tx=%h required 100000", move_tx); end
  endtask

  initial begin
    test_reset();
    test_black_timing();
    test_white();
    test_ac_cap();
    test_shifts();
    test_random();
    test_overrun();
    test_timeout();
    test_reset_mid_copy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
